// File: rtl/channel_reduce_n.sv
// channel_reduce_n: folds N words read from one channel into a single
// result (sum, max or min) and writes it to a second channel.
module channel_reduce_n #(
  parameter int WIDTH      = 32,
  parameter int N          = 4,
  parameter int MODE       = 0,
  parameter int CONTINUOUS = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] in_in_data,
  output logic             in_read_valid,
  output logic             in_rst,
  output logic             in_write_valid,
  input  logic [WIDTH-1:0] in_out_data,
  input  logic             in_read_ready,
  input  logic             in_write_ready,
  output logic [WIDTH-1:0] out_in_data,
  output logic             out_read_valid,
  output logic             out_rst,
  output logic             out_write_valid,
  input  logic [WIDTH-1:0] out_out_data,
  input  logic             out_read_ready,
  input  logic             out_write_ready,
  output logic             valid
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] INIT =
    (MODE == 2) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    READ,
    CAPTURE,
    WRITE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic             unused;

  assign in_in_data     = '0;
  assign in_rst         = 1'b0;
  assign in_write_valid = 1'b0;
  assign out_read_valid = 1'b0;
  assign out_rst        = 1'b0;
  assign out_in_data    = acc;

  assign unused = ^{in_write_ready, out_out_data, out_read_ready};

  // Combine the captured word into the running result.
  always_comb begin
    acc_nx = acc + in_out_data;
    unique case (1'b1)
      (MODE == 1): acc_nx = (in_out_data > acc) ? in_out_data : acc;
      (MODE == 2): acc_nx = (in_out_data < acc) ? in_out_data : acc;
      default: ;
    endcase
  end

  // Next state and strobes; all strobes are held low during reset.
  always_comb begin
    state_nx        = state;
    in_read_valid   = 1'b0;
    out_write_valid = 1'b0;
    valid           = 1'b0;
    if (rst) begin
      unique case (state)
        READ: begin
          if (in_read_ready) begin
            in_read_valid = 1'b1;
            state_nx      = CAPTURE;
          end
        end
        CAPTURE: begin
          state_nx = (cnt == LAST) ? WRITE : READ;
        end
        WRITE: begin
          if (out_write_ready) begin
            out_write_valid = 1'b1;
            state_nx        = DONE;
          end
        end
        DONE: begin
          valid = 1'b1;
          if (CONTINUOUS != 0) state_nx = READ;
        end
        default: state_nx = READ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= READ;
    else      state <= state_nx;
  end

  // Accumulator and element count; restart clears both on leaving DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= INIT;
      cnt <= '0;
    end else begin
      unique case (state)
        CAPTURE: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          if (CONTINUOUS != 0) begin
            acc <= INIT;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_reduce_n.sv
// tb_channel_reduce_n: drives several parameterisations of the reducer
// from channel models and compares results with a reference fold.
module tb_channel_reduce_n;

  localparam int NI = 6;
  localparam int WS[NI] = '{32, 8, 32, 32, 32, 32};
  localparam int NS[NI] = '{4, 4, 4, 4, 2, 1};
  localparam int MS[NI] = '{0, 0, 1, 2, 0, 0};
  localparam int CS[NI] = '{0, 0, 0, 0, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a[NI];
  logic [31:0] rdata[NI];
  logic        rready[NI];
  logic        wready[NI];
  logic        rvalid[NI];
  logic        wvalid[NI];
  logic        vld[NI];
  logic [31:0] odata[NI];
  logic        tie[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [WS[g]-1:0] iid;
    logic [WS[g]-1:0] oid;
    logic irst, iwv, orv, orst;
    channel_reduce_n #(
      .WIDTH(WS[g]), .N(NS[g]), .MODE(MS[g]), .CONTINUOUS(CS[g])
    ) u_dut (
      .clk(clk),
      .rst(rst_a[g]),
      .in_in_data(iid),
      .in_read_valid(rvalid[g]),
      .in_rst(irst),
      .in_write_valid(iwv),
      .in_out_data(rdata[g][WS[g]-1:0]),
      .in_read_ready(rready[g]),
      .in_write_ready(1'b1),
      .out_in_data(oid),
      .out_read_valid(orv),
      .out_rst(orst),
      .out_write_valid(wvalid[g]),
      .out_out_data({WS[g]{1'b1}}),
      .out_read_ready(1'b1),
      .out_write_ready(wready[g]),
      .valid(vld[g])
    );
    assign odata[g] = 32'(oid);
    assign tie[g] = |{iid, irst, iwv, orv, orst};
  end

  logic [31:0] mem[NI][64];
  int          len[NI];
  int          ptr[NI];

  logic [31:0] wlog[$];
  int reads, viol, vcyc, vpulse, first_v;
  int cmps = 0;
  int errs = 0;

  function automatic logic [31:0] wmask(input int k);
    return (WS[k] == 32) ? 32'hFFFF_FFFF : ((32'h1 << WS[k]) - 32'h1);
  endfunction

  function automatic logic [31:0] init_of(input int k);
    return (MS[k] == 2) ? wmask(k) : 32'h0;
  endfunction

  // Reference: fold of n words starting at s, by the mode's rule.
  function automatic logic [31:0] ref_red(input int k, input int s,
                                          input int n);
    longint      sum = 0;
    logic [31:0] r = init_of(k);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = mem[k][s + i] & wmask(k);
      sum += longint'(d);
      if (MS[k] == 1 && d > r) r = d;
      if (MS[k] == 2 && d < r) r = d;
    end
    if (MS[k] == 0) r = 32'(sum) & wmask(k);
    return r;
  endfunction

  task automatic load4(input int k, input logic [31:0] a, b, c, d);
    mem[k][0] = a; mem[k][1] = b; mem[k][2] = c; mem[k][3] = d;
    len[k] = 4;
    ptr[k] = 0;
  endtask

  task automatic do_reset(input int k);
    rst_a[k] = 1'b0;
    rready[k] = 1'b1;
    wready[k] = 1'b1;
    ptr[k] = 0;
    len[k] = 0;
    repeat (2) @(negedge clk);
    rst_a[k] = 1'b1;
    rready[k] = 1'b0;
  endtask

  // Channel model: present ready, log strobes, return data one cycle later.
  task automatic run(input int k, input int cycles, input int rstall,
                     input int wstall);
    int hold = 0;
    int wcnt = 0;
    logic prev_v = 1'b0;
    logic got;
    logic [31:0] pend;
    wlog.delete();
    reads = 0; viol = 0; vcyc = 0; vpulse = 0; first_v = -1;
    for (int c = 0; c < cycles; c++) begin
      rready[k] = (ptr[k] < len[k]) && (hold == 0);
      if (ptr[k] == len[k] && wcnt < wstall) begin
        wready[k] = 1'b0;
        wcnt++;
      end else begin
        wready[k] = 1'b1;
      end
      #1;
      got = rvalid[k];
      pend = mem[k][ptr[k] & 63];
      if (rvalid[k] && !rready[k]) viol++;
      if (wvalid[k] && !wready[k]) viol++;
      if (got) begin
        reads++;
        ptr[k]++;
        hold = rstall;
      end else if (hold > 0) begin
        hold--;
      end
      if (wvalid[k]) wlog.push_back(odata[k]);
      if (vld[k]) begin
        vcyc++;
        if (first_v < 0) first_v = c;
      end
      if (vld[k] && !prev_v) vpulse++;
      prev_v = vld[k];
      @(posedge clk);
      #1;
      if (got) rdata[k] = pend;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] wl(input int i);
    return (wlog.size() > i) ? wlog[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      rready[k] = 1'b1;
      wready[k] = 1'b1;
    end
    @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      cmps += 5;
      if (rvalid[k] !== 1'b0) begin errs++;
        $display("FAIL rst_rvalid[%0d]: got %b want 0", k, rvalid[k]); end
      if (wvalid[k] !== 1'b0) begin errs++;
        $display("FAIL rst_wvalid[%0d]: got %b want 0", k, wvalid[k]); end
      if (vld[k] !== 1'b0) begin errs++;
        $display("FAIL rst_valid[%0d]: got %b want 0", k, vld[k]); end
      if (odata[k] !== init_of(k)) begin errs++;
        $display("FAIL rst_acc[%0d]: got %0h want %0h", k, odata[k],
                 init_of(k)); end
      if (tie[k] !== 1'b0) begin errs++;
        $display("FAIL tied[%0d]: got %b want 0", k, tie[k]); end
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      rst_a[k] = 1'b1;
      rready[k] = 1'b0;
      wready[k] = 1'b0;
    end
    #1;
    cmps++;
    if (rvalid[0] !== 1'b0) begin errs++;
      $display("FAIL idle_rvalid: got %b want 0", rvalid[0]); end
    rready[0] = 1'b1;
    #1;
    cmps++;
    if (rvalid[0] !== 1'b1) begin errs++;
      $display("FAIL read_state: got %b want 1", rvalid[0]); end
    rready[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sum_basic();
    do_reset(0);
    load4(0, 1, 2, 3, 4);
    run(0, 20, 0, 0);
    cmps += 6;
    if (wlog.size() !== 1) begin errs++;
      $display("FAIL sum_writes: got %0d want 1", wlog.size()); end
    if (wl(0) !== 32'd10) begin errs++;
      $display("FAIL sum_result: got %0d want 10", wl(0)); end
    if (reads !== 4) begin errs++;
      $display("FAIL sum_reads: got %0d want 4", reads); end
    if (first_v !== 9) begin errs++;
      $display("FAIL sum_latency: got %0d want 9", first_v); end
    if (vcyc !== 11) begin errs++;
      $display("FAIL sum_valid_held: got %0d want 11", vcyc); end
    if (viol !== 0) begin errs++;
      $display("FAIL sum_strobe_rule: got %0d want 0", viol); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    load4(1, 200, 100, 0, 0);
    run(1, 14, 0, 0);
    cmps += 2;
    if (wl(0) !== 32'd44) begin errs++;
      $display("FAIL wrap_result: got %0d want 44", wl(0)); end
    if (wlog.size() !== 1) begin errs++;
      $display("FAIL wrap_writes: got %0d want 1", wlog.size()); end
  endtask

  task automatic test_max_min();
    do_reset(2);
    load4(2, 7, 32'hFFFF_FFFF, 3, 9);
    run(2, 14, 0, 0);
    cmps++;
    if (wl(0) !== 32'hFFFF_FFFF) begin errs++;
      $display("FAIL max_result: got %0h want ffffffff", wl(0)); end
    do_reset(3);
    load4(3, 7, 32'hFFFF_FFFF, 3, 9);
    run(3, 14, 0, 0);
    cmps++;
    if (wl(0) !== 32'd3) begin errs++;
      $display("FAIL min_result: got %0h want 3", wl(0)); end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    do_reset(0);
    load4(0, $urandom, $urandom, $urandom, $urandom);
    exp = ref_red(0, 0, 4);
    run(0, 60, 5, 4);
    cmps += 4;
    if (wl(0) !== exp) begin errs++;
      $display("FAIL stall_result: got %0h want %0h", wl(0), exp); end
    if (wlog.size() !== 1) begin errs++;
      $display("FAIL stall_writes: got %0d want 1", wlog.size()); end
    if (reads !== 4) begin errs++;
      $display("FAIL stall_reads: got %0d want 4", reads); end
    if (viol !== 0) begin errs++;
      $display("FAIL stall_strobe_rule: got %0d want 0", viol); end
  endtask

  task automatic test_continuous();
    do_reset(4);
    load4(4, 5, 6, 1, 1);
    run(4, 16, 0, 0);
    cmps += 5;
    if (wlog.size() !== 2) begin errs++;
      $display("FAIL cont_writes: got %0d want 2", wlog.size()); end
    if (wl(0) !== 32'd11) begin errs++;
      $display("FAIL cont_first: got %0d want 11", wl(0)); end
    if (wl(1) !== 32'd2) begin errs++;
      $display("FAIL cont_second: got %0d want 2", wl(1)); end
    if (vpulse !== 2) begin errs++;
      $display("FAIL cont_pulses: got %0d want 2", vpulse); end
    if (vcyc !== 2) begin errs++;
      $display("FAIL cont_valid_cycles: got %0d want 2", vcyc); end
  endtask

  task automatic test_n1();
    do_reset(5);
    for (int i = 0; i < 3; i++) mem[5][i] = $urandom;
    len[5] = 3;
    ptr[5] = 0;
    run(5, 14, 0, 0);
    cmps += 3;
    if (wlog.size() !== 3) begin errs++;
      $display("FAIL n1_writes: got %0d want 3", wlog.size()); end
    if (wl(2) !== mem[5][2]) begin errs++;
      $display("FAIL n1_last: got %0h want %0h", wl(2), mem[5][2]); end
    if (vpulse !== 3) begin errs++;
      $display("FAIL n1_pulses: got %0d want 3", vpulse); end
  endtask

  task automatic test_reset_mid();
    do_reset(0);
    load4(0, $urandom_range(1, 1000), 5, 7, 9);
    run(0, 4, 0, 0);
    rready[0] = 1'b1;
    wready[0] = 1'b1;
    #2;
    rst_a[0] = 1'b0;
    #1;
    cmps += 4;
    if (rvalid[0] !== 1'b0) begin errs++;
      $display("FAIL mid_rvalid: got %b want 0", rvalid[0]); end
    if (wvalid[0] !== 1'b0) begin errs++;
      $display("FAIL mid_wvalid: got %b want 0", wvalid[0]); end
    if (vld[0] !== 1'b0) begin errs++;
      $display("FAIL mid_valid: got %b want 0", vld[0]); end
    if (odata[0] !== 32'd0) begin errs++;
      $display("FAIL mid_acc: got %0h want 0", odata[0]); end
    repeat (3) @(negedge clk);
    load4(0, 1, 1, 1, 1);
    rst_a[0] = 1'b1;
    rready[0] = 1'b0;
    run(0, 20, 0, 0);
    cmps += 3;
    if (wl(0) !== 32'd4) begin errs++;
      $display("FAIL mid_result: got %0d want 4", wl(0)); end
    if (reads !== 4) begin errs++;
      $display("FAIL mid_reads: got %0d want 4", reads); end
    if (first_v !== 9) begin errs++;
      $display("FAIL mid_latency: got %0d want 9", first_v); end
  endtask

  task automatic test_random();
    int k, rs, ws;
    logic [31:0] exp;
    for (int t = 0; t < 8; t++) begin
      k = $urandom_range(0, 3);
      rs = $urandom_range(0, 3);
      ws = $urandom_range(0, 3);
      do_reset(k);
      for (int i = 0; i < 4; i++) begin
        mem[k][i] = ($urandom_range(0, 3) == 0) ? wmask(k) :
                    ($urandom & wmask(k));
      end
      len[k] = 4;
      exp = ref_red(k, 0, 4);
      run(k, 60, rs, ws);
      cmps += 3;
      if (wl(0) !== exp) begin errs++;
        $display("FAIL rand_result[%0d]: got %0h want %0h", k, wl(0), exp);
      end
      if (wlog.size() !== 1) begin errs++;
        $display("FAIL rand_writes[%0d]: got %0d want 1", k, wlog.size());
      end
      if (viol !== 0) begin errs++;
        $display("FAIL rand_strobe_rule[%0d]: got %0d want 0", k, viol);
      end
    end
    do_reset(4);
    for (int i = 0; i < 6; i++) mem[4][i] = $urandom;
    len[4] = 6;
    run(4, 50, $urandom_range(0, 2), 0);
    cmps += 4;
    if (wlog.size() !== 3) begin errs++;
      $display("FAIL rand_cont_writes: got %0d want 3", wlog.size()); end
    for (int j = 0; j < 3; j++) begin
      if (wl(j) !== ref_red(4, 2 * j, 2)) begin errs++;
        $display("FAIL rand_cont[%0d]: got %0h want %0h", j, wl(j),
                 ref_red(4, 2 * j, 2));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_a[k] = 1'b0;
      rready[k] = 1'b0;
      wready[k] = 1'b0;
      rdata[k] = '0;
      len[k] = 0;
      ptr[k] = 0;
    end
    test_reset();
    test_sum_basic();
    test_wrap();
    test_max_min();
    test_stall();
    test_continuous();
    test_n1();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
